ble_fifo_wr_ctrl: RTL and testbench

- Write-side control for the BLE PHY async FIFO.
- Owns the binary/Gray write pointer, the memory write address and enable, and the full/almost-full flags.
- Brings the read-domain Gray read pointer into the write clock domain through an internal multi-flop synchronizer.
- Pairs with the read-side control, which synchronizes W_ptr the other way.

---
 rtl/ble_fifo_wr_ctrl.sv | 108 ++++++++++
 tb/tb_ble_fifo_wr_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ble_fifo_wr_ctrl.sv
// Write-side pointer, address and flag control for the BLE PHY async FIFO.
// Define BLE_FIFO_DROP_CNT_EN to build the saturating dropped-write counter.
module ble_fifo_wr_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = 2
) (
    input  logic                  W_CLK,
    input  logic                  W_rst,
    input  logic                  W_inc,
    input  logic [ADDR_WIDTH:0]   R_ptr,
    input  logic                  W_ovf_clr,
    output logic                  W_en,
    output logic [ADDR_WIDTH-1:0] W_addr,
    output logic [ADDR_WIDTH:0]   W_ptr,
    output logic                  W_full,
    output logic                  W_almost_full,
    output logic [ADDR_WIDTH:0]   W_level,
    output logic                  W_ovf,
    output logic [7:0]            W_drop_cnt
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = PW'((1 << ADDR_WIDTH) - AF_THRESH);

    logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] sync_q;
    logic [ADDR_WIDTH:0] wq_rptr;
    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] wbin_next;
    logic [ADDR_WIDTH:0] wgray_next;
    logic [ADDR_WIDTH:0] full_target;
    logic [ADDR_WIDTH:0] level_next;
    logic                drop_evt;

    always_ff @(posedge W_CLK or posedge W_rst) begin
        if (W_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], R_ptr};
        end
    end

    assign wq_rptr = sync_q[SYNC_STAGES-1];

    always_comb begin
        rbin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            rbin[i] = ^(wq_rptr >> i);
        end
    end

    assign W_en       = W_inc & ~W_full;
    assign drop_evt   = W_inc & W_full;
    assign wbin_next  = wbin + PW'(W_en);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign level_next = wbin_next - rbin;
    assign W_addr     = wbin[ADDR_WIDTH-1:0];

    // Full when the next write pointer is exactly one lap ahead of the
    // synchronized (possibly stale) read pointer, so full is never optimistic.
    assign full_target = {~wq_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq_rptr[ADDR_WIDTH-2:0]};

    always_ff @(posedge W_CLK or posedge W_rst) begin
        if (W_rst) begin
            wbin          <= '0;
            W_ptr         <= '0;
            W_full        <= 1'b0;
            W_almost_full <= 1'b0;
            W_level       <= '0;
        end else begin
            wbin          <= wbin_next;
            W_ptr         <= wgray_next;
            W_full        <= (wgray_next == full_target);
            W_almost_full <= (level_next >= AF_LEVEL);
            W_level       <= level_next;
        end
    end

    always_ff @(posedge W_CLK or posedge W_rst) begin
        if (W_rst) begin
            W_ovf <= 1'b0;
        end else begin
            W_ovf <= drop_evt | (W_ovf & ~W_ovf_clr);
        end
    end

`ifdef BLE_FIFO_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge W_CLK or posedge W_rst) begin
        if (W_rst) begin
            drop_q <= '0;
        end else if (drop_evt) begin
            if (drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end else if (W_ovf_clr) begin
            drop_q <= '0;
        end
    end

    assign W_drop_cnt = drop_q;
`else
    assign W_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ble_fifo_wr_ctrl.sv
// Scoreboard bench for ble_fifo_wr_ctrl: occupancy model based on write/read totals.
module tb_ble_fifo_wr_ctrl;

    localparam int AW    = 4;
    localparam int SS    = 2;
    localparam int AFT   = 2;
    localparam int DEPTH = 16;

    logic       W_CLK = 1'b0;
    logic       W_rst;
    logic       W_inc;
    logic [4:0] R_ptr;
    logic       W_ovf_clr;
    logic       W_en;
    logic [3:0] W_addr;
    logic [4:0] W_ptr;
    logic       W_full;
    logic       W_almost_full;
    logic [4:0] W_level;
    logic       W_ovf;
    logic [7:0] W_drop_cnt;

    ble_fifo_wr_ctrl #(
        .ADDR_WIDTH (AW),
        .SYNC_STAGES(SS),
        .AF_THRESH  (AFT)
    ) dut (
        .W_CLK        (W_CLK),
        .W_rst        (W_rst),
        .W_inc        (W_inc),
        .R_ptr        (R_ptr),
        .W_ovf_clr    (W_ovf_clr),
        .W_en         (W_en),
        .W_addr       (W_addr),
        .W_ptr        (W_ptr),
        .W_full       (W_full),
        .W_almost_full(W_almost_full),
        .W_level      (W_level),
        .W_ovf        (W_ovf),
        .W_drop_cnt   (W_drop_cnt)
    );

    always #5 W_CLK = ~W_CLK;

    typedef struct {
        int en;
        int addr;
        int ptr;
        int full;
        int af;
        int level;
        int ovf;
        int drop;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: total accepted writes, total reads, and the read totals the
    // write domain has seen at recent edges (oldest first).
    int m_wr, m_rd, m_level, m_drop, m_full, m_af, m_ovf;
    int m_hist[$];

    function automatic int gray(int b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_W_en"}, W_en, 0);
        check({tag, "_W_addr"}, W_addr, 0);
        check({tag, "_W_ptr"}, W_ptr, 0);
        check({tag, "_W_full"}, W_full, 0);
        check({tag, "_W_almost_full"}, W_almost_full, 0);
        check({tag, "_W_level"}, W_level, 0);
        check({tag, "_W_ovf"}, W_ovf, 0);
        check({tag, "_W_drop_cnt"}, W_drop_cnt, 0);
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_level = 0; m_drop = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
        m_hist.delete();
        repeat (SS) m_hist.push_back(0);
    endtask

    // Drive one cycle of inputs (called at posedge+1), queue what the DUT
    // must show during it, then advance the model across the coming edge.
    task automatic cycle(int inc, int rd, int clr);
        exp_t e;
        int   stale;
        int   ovf_evt;
        W_inc     = inc[0];
        W_ovf_clr = clr[0];
        m_rd      = rd;
        R_ptr     = 5'(gray(rd % 32));
        e.en    = (inc != 0 && m_full == 0) ? 1 : 0;
        e.addr  = m_wr % DEPTH;
        e.ptr   = gray(m_wr % 32);
        e.full  = m_full;
        e.af    = m_af;
        e.level = m_level;
        e.ovf   = m_ovf;
        e.drop  = m_drop;
        sb.push_back(e);
        ovf_evt = (inc != 0 && m_full != 0) ? 1 : 0;
        m_wr    = m_wr + e.en;
        stale   = m_hist.pop_front();
        m_hist.push_back(rd);
        m_level = m_wr - stale;
        m_full  = (m_level == DEPTH) ? 1 : 0;
        m_af    = (m_level >= DEPTH - AFT) ? 1 : 0;
        m_ovf   = (ovf_evt != 0 || (m_ovf != 0 && clr == 0)) ? 1 : 0;
`ifdef BLE_FIFO_DROP_CNT_EN
        if (ovf_evt != 0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        else if (clr != 0) m_drop = 0;
`endif
        @(posedge W_CLK);
        #1;
    endtask

    task automatic do_reset();
        W_rst = 1'b1; W_inc = 1'b0; W_ovf_clr = 1'b0; R_ptr = '0;
        @(posedge W_CLK);
        #1;
        W_rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every cycle the DUT presents its outputs; compare at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge W_CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("W_en", W_en, e.en);
                check("W_addr", W_addr, e.addr);
                check("W_ptr", W_ptr, e.ptr);
                check("W_full", W_full, e.full);
                check("W_almost_full", W_almost_full, e.af);
                check("W_level", W_level, e.level);
                check("W_ovf", W_ovf, e.ovf);
                check("W_drop_cnt", W_drop_cnt, e.drop);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd;
        W_rst = 1'b1; W_inc = 1'b0; W_ovf_clr = 1'b0; R_ptr = '0;
        #1;
        check_all_zero("async_reset");
        @(posedge W_CLK);
        #1;
        W_rst = 1'b0;
        model_reset();

        // Fill from empty, then overflow attempts with a clear in the middle.
        repeat (16) cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        cycle(1, 0, 0);
        // Remote read of 4 entries propagates through the synchronizer.
        repeat (5) cycle(0, 4, 0);
        cycle(0, 4, 1);

        // 40 writes with the reader trailing two entries behind.
        do_reset();
        repeat (40) begin
            rd = (m_wr >= 2) ? m_wr - 2 : 0;
            cycle(1, rd, 0);
        end
        repeat (3) cycle(0, m_wr, 0);

        // Reset asserted between edges in the middle of a burst.
        do_reset();
        repeat (7) cycle(1, 0, 0);
        W_inc = 1'b1;
        #2;
        W_rst = 1'b1;
        W_inc = 1'b0;
        #1;
        check_all_zero("mid_burst_reset");
        @(posedge W_CLK);
        #1;
        W_rst = 1'b0;
        model_reset();
        repeat (3) cycle(1, 0, 0);

        // Overflow set and clear on the same edge while full.
        do_reset();
        repeat (16) cycle(1, 0, 0);
        cycle(1, 0, 1);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // Randomized traffic: slow reader first, then a faster one.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            int inc, clr;
            inc = ($urandom_range(0, 3) != 0) ? 1 : 0;
            clr = ($urandom_range(0, 15) == 0) ? 1 : 0;
            rd  = m_rd;
            if (rd < m_wr) begin
                if ((i < 250 && $urandom_range(0, 2) == 0) ||
                    (i >= 250 && $urandom_range(0, 3) != 0))
                    rd = rd + 1;
            end
            cycle(inc, rd, clr);
        end

        repeat (3) @(posedge W_CLK);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
